// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH-entry {pc, instr} buffer with push/pop/flush; the head
//                entry is read straight from the storage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [31:0]              i_push_pc,
    input  logic [31:0]              i_push_instr,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [31:0]              o_head_pc,
    output logic [31:0]              o_head_instr,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_count = (c_ptr_w + 1)'(DEPTH);

    logic [31:0]        r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_ptr_w:0]   r_count_q,  w_count_d;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (i_push) w_wr_ptr_d = r_wr_ptr_q + c_ptr_w'(1);
            if (i_pop)  w_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(1);
            w_count_d = r_count_q + (c_ptr_w + 1)'(i_push) - (c_ptr_w + 1)'(i_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Payload storage needs no reset: it is only observed when count > 0.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem_pc[r_wr_ptr_q]    <= i_push_pc;
            r_mem_instr[r_wr_ptr_q] <= i_push_instr;
        end
    end

    assign o_head_pc    = r_mem_pc[r_rd_ptr_q];
    assign o_head_instr = r_mem_instr[r_rd_ptr_q];
    assign o_count      = r_count_q;
    assign o_empty      = (r_count_q == '0);
    assign o_full       = (r_count_q == c_full_count);

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch with BOOT/RUN/FLUSH control, in-order
//                response buffering and redirect squashing.
//                Optional macro FETCH_PERF_EN adds perf_fetched/perf_stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    fetch_state_e       r_state_q,  w_state_d;
    logic [31:0]        r_pc_q,     w_pc_d;
    logic [31:0]        r_rsp_pc_q, w_rsp_pc_d;
    logic [c_cnt_w-1:0] r_out_q,    w_out_d;
    logic [c_cnt_w-1:0] r_stale_q,  w_stale_d;

    logic               w_req_fire;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [c_cnt_w-1:0] w_occ;
    logic [31:0]        w_head_pc;
    logic [31:0]        w_head_instr;
    logic               w_boot;
    logic               w_unused_ok;

    assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

    assign w_boot         = (r_state_q == FETCH_BOOT);
    assign imem_req_valid = (r_state_q == FETCH_RUN) &&
                            (({1'b0, r_out_q} + {1'b0, w_occ}) < c_depth);
    assign imem_req_addr  = r_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Stale responses are only ever pending while in FLUSH.
    assign w_push   = imem_rsp_valid && (r_stale_q == '0) && !redirect_valid;
    assign id_valid = !w_empty && !redirect_valid && !w_boot;
    assign w_pop    = id_valid && id_ready;
    assign id_instr = (w_boot || w_empty) ? NOP_INSTR : w_head_instr;
    assign id_pc    = (w_boot || w_empty) ? RESET_PC  : w_head_pc;

    always_comb begin
        w_pc_d     = r_pc_q;
        w_rsp_pc_d = r_rsp_pc_q;
        w_out_d    = r_out_q + c_cnt_w'(w_req_fire) - c_cnt_w'(imem_rsp_valid);
        w_stale_d  = r_stale_q;
        w_state_d  = r_state_q;

        if (redirect_valid) begin
            w_pc_d     = {redirect_pc[31:2], 2'b00};
            w_rsp_pc_d = {redirect_pc[31:2], 2'b00};
            w_stale_d  = w_out_d;
        end else begin
            if (w_req_fire) w_pc_d = r_pc_q + 32'd4;
            if (w_push) w_rsp_pc_d = r_rsp_pc_q + 32'd4;
            if (imem_rsp_valid && (r_stale_q != '0)) w_stale_d = r_stale_q - c_cnt_w'(1);
        end

        if (w_boot) w_state_d = FETCH_RUN;
        else        w_state_d = (w_stale_d != '0) ? FETCH_FLUSH : FETCH_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= FETCH_BOOT;
            r_pc_q     <= RESET_PC;
            r_rsp_pc_q <= RESET_PC;
            r_out_q    <= '0;
            r_stale_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_rsp_pc_q <= w_rsp_pc_d;
            r_out_q    <= w_out_d;
            r_stale_q  <= w_stale_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_pc    (r_rsp_pc_q),
        .i_push_instr (imem_rsp_data),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_count      (w_occ)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched_q, w_perf_fetched_d;
    logic [31:0] r_perf_stall_q,   w_perf_stall_d;

    always_comb begin
        w_perf_fetched_d = r_perf_fetched_q + {31'd0, w_pop};
        w_perf_stall_d   = r_perf_stall_q + {31'd0, (id_valid && !id_ready)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched_q <= '0;
            r_perf_stall_q   <= '0;
        end else begin
            r_perf_fetched_q <= w_perf_fetched_d;
            r_perf_stall_q   <= w_perf_stall_d;
        end
    end

    assign perf_fetched = r_perf_fetched_q;
    assign perf_stall   = r_perf_stall_q;
`endif

`ifndef SYNTHESIS
    // Request throttling keeps outstanding + occupancy <= DEPTH, so a
    // response into a full buffer means the memory broke protocol.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && w_full));
`endif

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries and max in-flight requests, legal values 2 or 4.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  in-order response valid, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump taken, one-cycle pulse.
REQ-011 SHALL have port redirect_pc  input  32  new fetch target; bits [1:0] ignored.
REQ-012 SHALL have port id_valid  output  1  instruction available to decode.
REQ-013 SHALL have port id_ready  input  1  decode accepts instruction.
REQ-014 SHALL have port id_instr  output  32  instruction word to decode and immediate extension.
REQ-015 SHALL have port id_pc  output  32  address of id_instr.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, FLUSH; reset enters BOOT; BOOT -> RUN after exactly one cycle.
REQ-017 SHALL assert imem_req_valid only in RUN and when outstanding + occupancy < DEPTH.
REQ-018 SHALL advance fetch PC by 4 on each cycle where imem_req_valid and imem_req_ready are both high.
REQ-019 SHALL keep imem_req_addr stable while imem_req_valid is high and imem_req_ready low, except on redirect.
REQ-020 SHALL write each non-stale response into the buffer tail with its PC; id outputs come from the registered head, so response at cycle N gives id_valid at N+1.
REQ-021 SHALL pop the head when id_valid and id_ready are both high; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-022 SHALL force id_valid low combinationally in any cycle where redirect_valid is high.
REQ-023 On redirect: fetch PC <= {redirect_pc[31:2],2'b00}, buffer emptied, stale count <= outstanding, including a request accepted in the same cycle; next state FLUSH if stale count > 0, else RUN.
REQ-024 In FLUSH SHALL issue no requests, discard responses while decrementing stale count, and go to RUN on the cycle stale count reaches 0.
REQ-025 A redirect during FLUSH SHALL update the PC and keep FLUSH; redirect has priority over all other events.
REQ-026 SHALL never overflow the buffer; a response arriving while full is a protocol error and SHALL assert only in simulation.
REQ-027 Outstanding and occupancy counters SHALL saturate at neither bound: wrap-free by construction, width clog2(DEPTH)+1.

Reset
REQ-028 On rst: state BOOT, PC = RESET_PC, buffer empty, outstanding = 0, stale = 0.
REQ-029 During reset and BOOT: imem_req_valid = 0, id_valid = 0, id_instr = 32'h0000_0013 (NOP), id_pc = RESET_PC.
REQ-030 Reset asserted mid-transaction SHALL drop all in-flight responses; memory is reset with the same rst.

Configuration
REQ-031 With FETCH_PERF_EN defined SHALL add outputs perf_fetched (32, count of id handshakes) and perf_stall (32, cycles id_valid=1 and id_ready=0), both reset to 0 and wrapping at 2^32.
REQ-032 Without FETCH_PERF_EN the perf ports and counters SHALL NOT exist.

Structure
REQ-033 Shared package cpu_pkg SHALL hold NOP_INSTR, the fetch FSM state enum, and the default RESET_PC.
REQ-034 The buffer SHALL be sub-module fetch_fifo (DEPTH entries of {pc, instr}, push/pop/flush, full/empty).

Verification
REQ-035 Reset release, memory always ready, 1-cycle latency, id_ready=1 -> addresses 0,4,8,... and first id_valid in cycle 3 after reset.
REQ-036 id_ready=0 for 5 cycles -> buffer holds 2, imem_req_valid=0, id_instr/id_pc stable, perf_stall=5 if FETCH_PERF_EN.
REQ-037 Redirect to 32'h0000_0102 with 2 outstanding -> FLUSH, 2 responses dropped, next request address 32'h0000_0100.
REQ-038 Redirect in same cycle as request acceptance -> that response discarded, never reaches id.
REQ-039 Second redirect to 32'h40 during FLUSH -> remains FLUSH until stale count reaches 0, then fetches 32'h40.
REQ-040 rst asserted with 2 in flight -> all outputs at reset values in the same cycle, fetch restarts at RESET_PC.
